// File: rtl/stream_source.sv
// stream_source: forward-stream transmit endpoint that stamps host beats with
// stream/chunk identifiers and obeys PAUSE/RESUME/CREDIT instructions.
module stream_source #(
    parameter int DATA_WIDTH = 512,
    parameter int STREAM_ID_NUM = 16,
    parameter int CHUNK_ID_NUM = 32,
    parameter int CHANNEL_ID_NUM = 1024,
    parameter int STATE_WIDTH = 32,
    parameter int INSTRUCTION_WIDTH = 2,
    parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
    parameter int INIT_CREDITS = 16,
    localparam int STREAM_ID_WIDTH = $clog2(STREAM_ID_NUM),
    localparam int CHUNK_ID_WIDTH = $clog2(CHUNK_ID_NUM),
    localparam int CHANNEL_ID_WIDTH = $clog2(CHANNEL_ID_NUM),
    localparam int IPW = INSTRUCTION_PARAMETER_WIDTH
) (
    input  logic                         clk,
    input  logic                         rstnIn,
    input  logic [STREAM_ID_WIDTH-1:0]   cfgStreamID,
    input  logic                         hostIn_Valid,
    output logic                         hostIn_Ready,
    input  logic [DATA_WIDTH-1:0]        hostIn_Data,
    input  logic                         hostIn_Last,
    input  logic [CHANNEL_ID_WIDTH-1:0]  hostIn_ChannelID,
    input  logic [STATE_WIDTH-1:0]       hostIn_State,
    output logic [DATA_WIDTH-1:0]        front_Data,
    output logic                         front_Last,
    output logic [CHANNEL_ID_WIDTH-1:0]  front_ChannelID,
    output logic [STATE_WIDTH-1:0]       front_State,
    output logic [1:0]                   front_Type,
    output logic [STREAM_ID_WIDTH-1:0]   front_StreamID,
    output logic [CHUNK_ID_WIDTH-1:0]    front_ChunkID,
    input  logic [INSTRUCTION_WIDTH-1:0] front_InstructionType,
    input  logic [STREAM_ID_WIDTH-1:0]   front_InstructionStreamID,
    input  logic [CHANNEL_ID_WIDTH-1:0]  front_InstructionChannelID,
    input  logic [IPW-1:0]               front_InstructionParameter,
    output logic                         stat_Paused,
    output logic [IPW-1:0]               stat_Credits,
    output logic                         stat_Oversize
);
    localparam logic [1:0] IDLE = 2'd0, PKT = 2'd1, PAUSE_PEND = 2'd2, PAUSED = 2'd3;

    logic [1:0] state, nextState;
    logic [CHUNK_ID_WIDTH-1:0] chunk;
    logic [IPW-1:0] credits;
    logic [IPW:0] creditSum;
    logic accept, forced, effLast, matched, pause, resume, credit;
    logic unusedChannel;

    assign unusedChannel = ^front_InstructionChannelID;
    assign hostIn_Ready = (state != PAUSED) && (credits != '0);
    assign accept = hostIn_Valid && hostIn_Ready;
    assign forced = accept && !hostIn_Last && (chunk == CHUNK_ID_WIDTH'(CHUNK_ID_NUM - 1));
    assign effLast = hostIn_Last || forced;
    assign matched = (front_InstructionType != '0) && (front_InstructionStreamID == cfgStreamID);
    assign pause = matched && front_InstructionType == INSTRUCTION_WIDTH'(1);
    assign resume = matched && front_InstructionType == INSTRUCTION_WIDTH'(2);
    assign credit = matched && front_InstructionType == INSTRUCTION_WIDTH'(3);
    // Accept only happens with credits != 0, so the subtraction never wraps.
    assign creditSum = {1'b0, credits} - (IPW + 1)'(accept) + (credit ? {1'b0, front_InstructionParameter} : '0);
    assign stat_Paused = state == PAUSED;
    assign stat_Credits = credits;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:       nextState = (accept && !effLast) ? (pause ? PAUSE_PEND : PKT) : (pause ? PAUSED : IDLE);
            PKT:        nextState = (accept && effLast) ? (pause ? PAUSED : IDLE) : (pause ? PAUSE_PEND : PKT);
            PAUSE_PEND: nextState = (accept && effLast) ? (resume ? IDLE : PAUSED) : (resume ? PKT : PAUSE_PEND);
            default:    nextState = resume ? IDLE : PAUSED;
        endcase
    end

    always_ff @(posedge clk or negedge rstnIn) begin
        if (!rstnIn) begin
            state <= IDLE;
            chunk <= '0;
            credits <= IPW'(INIT_CREDITS);
            front_Data <= '0;
            front_Last <= 1'b0;
            front_ChannelID <= '0;
            front_State <= '0;
            front_Type <= 2'd0;
            front_StreamID <= '0;
            front_ChunkID <= '0;
            stat_Oversize <= 1'b0;
        end else begin
            state <= nextState;
            credits <= creditSum[IPW] ? '1 : creditSum[IPW-1:0];
            front_Type <= accept ? 2'd1 : 2'd0;
            stat_Oversize <= forced;
            if (accept) begin
                chunk <= effLast ? '0 : chunk + 1'b1;
                front_Data <= hostIn_Data;
                front_Last <= effLast;
                front_ChannelID <= hostIn_ChannelID;
                front_State <= hostIn_State;
                front_StreamID <= cfgStreamID;
                front_ChunkID <= chunk;
            end
        end
    end
endmodule

// File: tb/tb_stream_source.sv
// tb_stream_source: directed self-checking bench for stream_source.
module tb_stream_source;
    logic clk = 1'b0;
    logic rstnIn;
    logic [3:0] cfgStreamID = 4'd5;
    logic hostIn_Valid, hostIn_Ready, hostIn_Last;
    logic [511:0] hostIn_Data, front_Data;
    logic [9:0] hostIn_ChannelID, front_ChannelID, front_InstructionChannelID;
    logic [31:0] hostIn_State, front_State;
    logic front_Last, stat_Paused, stat_Oversize;
    logic [1:0] front_Type, front_InstructionType;
    logic [3:0] front_StreamID, front_InstructionStreamID;
    logic [4:0] front_ChunkID;
    logic [15:0] front_InstructionParameter, stat_Credits;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_source dut (
        .clk(clk), .rstnIn(rstnIn), .cfgStreamID(cfgStreamID),
        .hostIn_Valid(hostIn_Valid), .hostIn_Ready(hostIn_Ready), .hostIn_Data(hostIn_Data),
        .hostIn_Last(hostIn_Last), .hostIn_ChannelID(hostIn_ChannelID), .hostIn_State(hostIn_State),
        .front_Data(front_Data), .front_Last(front_Last), .front_ChannelID(front_ChannelID),
        .front_State(front_State), .front_Type(front_Type), .front_StreamID(front_StreamID),
        .front_ChunkID(front_ChunkID), .front_InstructionType(front_InstructionType),
        .front_InstructionStreamID(front_InstructionStreamID),
        .front_InstructionChannelID(front_InstructionChannelID),
        .front_InstructionParameter(front_InstructionParameter),
        .stat_Paused(stat_Paused), .stat_Credits(stat_Credits), .stat_Oversize(stat_Oversize)
    );

    task automatic drive(input logic v, input logic l, input logic [31:0] d);
        hostIn_Valid = v;
        hostIn_Last = l;
        hostIn_Data = {16{d}};
        hostIn_ChannelID = d[9:0];
        hostIn_State = ~d;
    endtask

    task automatic instr(input logic [1:0] t, input logic [3:0] s, input logic [15:0] p);
        front_InstructionType = t;
        front_InstructionStreamID = s;
        front_InstructionChannelID = 10'h3FF;
        front_InstructionParameter = p;
    endtask

    task automatic test_reset;
        rstnIn = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        instr(2'd0, 4'd0, 16'd0);
        repeat (2) @(negedge clk);
        checks++; if (front_Type !== 2'd0) begin errors++; $display("FAIL rst_type got %0d exp 0", front_Type); end
        checks++; if (front_Data !== '0) begin errors++; $display("FAIL rst_data got %0h exp 0", front_Data[31:0]); end
        checks++; if (stat_Credits !== 16'd16) begin errors++; $display("FAIL rst_credits got %0d exp 16", stat_Credits); end
        checks++; if (hostIn_Ready !== 1'b1 || stat_Paused !== 1'b0) begin errors++; $display("FAIL rst_ready got %b/%b exp 1/0", hostIn_Ready, stat_Paused); end
        rstnIn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_packet3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 2, 32'hA000 + i);
            @(negedge clk);
            checks++; if (front_Type !== 2'd1 || front_ChunkID !== 5'(i) || front_Last !== (i == 2)) begin errors++; $display("FAIL pkt3_beat%0d got type %0d chunk %0d last %b exp 1 %0d %b", i, front_Type, front_ChunkID, front_Last, i, i == 2); end
            checks++; if (front_Data !== {16{32'hA000 + i}} || front_StreamID !== 4'd5 || front_ChannelID !== 10'(32'hA000 + i) || front_State !== ~(32'hA000 + i)) begin errors++; $display("FAIL pkt3_fields%0d got data %0h sid %0d exp %0h 5", i, front_Data[31:0], front_StreamID, 32'hA000 + i); end
        end
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (front_Type !== 2'd0 || front_Data[31:0] !== 32'hA002) begin errors++; $display("FAIL pkt3_idle got type %0d data %0h exp 0 a002", front_Type, front_Data[31:0]); end
        checks++; if (stat_Credits !== 16'd13) begin errors++; $display("FAIL pkt3_credits got %0d exp 13", stat_Credits); end
    endtask

    task automatic test_pause;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 3, 32'hB000 + i);
            if (i == 1) instr(2'd1, 4'd5, 16'd0); else instr(2'd0, 4'd0, 16'd0);
            checks++; if (hostIn_Ready !== 1'b1) begin errors++; $display("FAIL pause_ready%0d got %b exp 1", i, hostIn_Ready); end
            @(negedge clk);
            checks++; if (front_Type !== 2'd1 || front_ChunkID !== 5'(i) || front_Last !== (i == 3)) begin errors++; $display("FAIL pause_beat%0d got type %0d chunk %0d last %b exp 1 %0d %b", i, front_Type, front_ChunkID, front_Last, i, i == 3); end
        end
        instr(2'd0, 4'd0, 16'd0);
        checks++; if (stat_Paused !== 1'b1 || hostIn_Ready !== 1'b0) begin errors++; $display("FAIL pause_state got paused %b ready %b exp 1 0", stat_Paused, hostIn_Ready); end
        drive(1'b1, 1'b1, 32'hB100);
        @(negedge clk);
        checks++; if (front_Type !== 2'd0) begin errors++; $display("FAIL pause_block got type %0d exp 0", front_Type); end
        drive(1'b0, 1'b0, 32'h0);
        instr(2'd2, 4'd5, 16'd0);
        @(negedge clk);
        instr(2'd0, 4'd0, 16'd0);
        checks++; if (stat_Paused !== 1'b0 || hostIn_Ready !== 1'b1) begin errors++; $display("FAIL resume got paused %b ready %b exp 0 1", stat_Paused, hostIn_Ready); end
        checks++; if (stat_Credits !== 16'd9) begin errors++; $display("FAIL pause_credits got %0d exp 9", stat_Credits); end
    endtask

    task automatic test_credits;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 32'hC000 + i);
            @(negedge clk);
            checks++; if (front_Type !== 2'd1) begin errors++; $display("FAIL credit_beat%0d got type %0d exp 1", i, front_Type); end
        end
        checks++; if (hostIn_Ready !== 1'b0 || stat_Credits !== 16'd0) begin errors++; $display("FAIL credit_empty got ready %b credits %0d exp 0 0", hostIn_Ready, stat_Credits); end
        @(negedge clk);
        checks++; if (front_Type !== 2'd0) begin errors++; $display("FAIL credit_block got type %0d exp 0", front_Type); end
        drive(1'b0, 1'b0, 32'h0);
        instr(2'd3, 4'd5, 16'd5);
        @(negedge clk);
        checks++; if (stat_Credits !== 16'd5 || hostIn_Ready !== 1'b1) begin errors++; $display("FAIL credit_refill got credits %0d ready %b exp 5 1", stat_Credits, hostIn_Ready); end
        drive(1'b1, 1'b1, 32'hC100);
        @(negedge clk);
        checks++; if (stat_Credits !== 16'd9 || front_Type !== 2'd1) begin errors++; $display("FAIL credit_concurrent got credits %0d type %0d exp 9 1", stat_Credits, front_Type); end
        drive(1'b0, 1'b0, 32'h0);
        instr(2'd0, 4'd0, 16'd0);
    endtask

    task automatic test_unmatched;
        instr(2'd1, 4'd6, 16'd0);
        @(negedge clk);
        checks++; if (stat_Paused !== 1'b0 || hostIn_Ready !== 1'b1) begin errors++; $display("FAIL unmatched_pause got paused %b ready %b exp 0 1", stat_Paused, hostIn_Ready); end
        instr(2'd3, 4'd6, 16'd100);
        @(negedge clk);
        checks++; if (stat_Credits !== 16'd9) begin errors++; $display("FAIL unmatched_credit got %0d exp 9", stat_Credits); end
        instr(2'd3, 4'd5, 16'd7);
        @(negedge clk);
        checks++; if (stat_Credits !== 16'd16) begin errors++; $display("FAIL credit_add got %0d exp 16", stat_Credits); end
        instr(2'd3, 4'd5, 16'hFFFF);
        @(negedge clk);
        checks++; if (stat_Credits !== 16'hFFFF) begin errors++; $display("FAIL credit_sat got %0h exp ffff", stat_Credits); end
        instr(2'd0, 4'd0, 16'd0);
    endtask

    task automatic test_oversize;
        for (int i = 0; i < 33; i++) begin
            drive(1'b1, i == 32, 32'hD000 + i);
            @(negedge clk);
            checks++; if (front_Type !== 2'd1 || front_ChunkID !== 5'(i < 32 ? i : 0) || front_Last !== (i >= 31) || stat_Oversize !== (i == 31)) begin errors++; $display("FAIL oversize_beat%0d got chunk %0d last %b ovs %b exp %0d %b %b", i, front_ChunkID, front_Last, stat_Oversize, i < 32 ? i : 0, i >= 31, i == 31); end
        end
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        checks++; if (stat_Oversize !== 1'b0 || stat_Credits !== 16'hFFDE) begin errors++; $display("FAIL oversize_end got ovs %b credits %0h exp 0 ffde", stat_Oversize, stat_Credits); end
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 1'b0, 32'hE000);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'hE001);
        @(negedge clk);
        #2 rstnIn = 1'b0;
        #1;
        checks++; if (front_Type !== 2'd0 || front_Data !== '0 || front_ChunkID !== 5'd0 || front_Last !== 1'b0) begin errors++; $display("FAIL rstmid_out got type %0d data %0h chunk %0d exp 0 0 0", front_Type, front_Data[31:0], front_ChunkID); end
        checks++; if (stat_Credits !== 16'd16 || hostIn_Ready !== 1'b1) begin errors++; $display("FAIL rstmid_credits got %0d ready %b exp 16 1", stat_Credits, hostIn_Ready); end
        drive(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rstnIn = 1'b1;
        drive(1'b1, 1'b1, 32'hE100);
        @(negedge clk);
        checks++; if (front_Type !== 2'd1 || front_ChunkID !== 5'd0 || front_Last !== 1'b1 || stat_Credits !== 16'd15) begin errors++; $display("FAIL rstmid_next got type %0d chunk %0d last %b credits %0d exp 1 0 1 15", front_Type, front_ChunkID, front_Last, stat_Credits); end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_packet3();
        test_pause();
        test_credits();
        test_unmatched();
        test_oversize();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
